// File: rtl/isr_pkg.sv
// Shared definitions for the square-root wrapper: widths, FSM encoding, word tags.
package isr_pkg;

   localparam int VIN_W       = 128;
   localparam int ROUT_W      = 129;
   localparam int VOUT_W      = 128;
   localparam int DATA_W      = 48;
   localparam int TIMEOUT_CYC = 1024;
   localparam int CNT_W       = 10;
   localparam int WIDX_W      = 3;
   localparam int PAY_W       = 44;

   localparam logic [2:0] TAG_V0 = 3'b001;
   localparam logic [2:0] TAG_V1 = 3'b010;
   localparam logic [2:0] TAG_V2 = 3'b011;
   localparam logic [2:0] TAG_R0 = 3'b100;
   localparam logic [2:0] TAG_R1 = 3'b101;
   localparam logic [2:0] TAG_R2 = 3'b110;

   localparam logic [WIDX_W-1:0] LAST_WIDX = 3'd5;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } isr_state_e;

endpackage

// File: rtl/isr_pack.sv
// Combinational formatter: selects one of six tagged output words from the captured root/remainder.
module isr_pack
   import isr_pkg::*;
(
   input  logic [WIDX_W-1:0] idx,
   input  logic [VOUT_W-1:0] v,
   input  logic [ROUT_W-1:0] r,
   output logic [DATA_W-1:0] word
);

   // Root words carry flag 0, remainder words flag 1; last slices are left-justified.
   always_comb begin
      word = '0;
      unique case (idx)
         3'd0:    word = {TAG_V0, 1'b0, v[127:84]};
         3'd1:    word = {TAG_V1, 1'b0, v[83:40]};
         3'd2:    word = {TAG_V2, 1'b0, v[39:0], 4'b0000};
         3'd3:    word = {TAG_R0, 1'b1, r[128:85]};
         3'd4:    word = {TAG_R1, 1'b1, r[84:41]};
         3'd5:    word = {TAG_R2, 1'b1, r[40:0], 3'b000};
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/isr_ctrl.sv
// Control wrapper for a square-root core: collects a tagged 3-word radicand, runs the core
// with a cycle timeout, and streams the captured root and remainder as six tagged words.
module isr_ctrl
   import isr_pkg::*;
#(
   parameter int VIN     = VIN_W,
   parameter int ROUT    = ROUT_W,
   parameter int VOUT    = VOUT_W,
   parameter int DATAOUT = DATA_W,
   parameter int TIMEOUT = TIMEOUT_CYC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DATAOUT-1:0] din,
   input  logic               din_valid,
   output logic               din_ready,
   output logic [VIN-1:0]     vin,
   output logic               run,
   input  logic               calcend,
   input  logic [ROUT-1:0]    rout,
   input  logic [VOUT-1:0]    vout,
   output logic [DATAOUT-1:0] dout,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic               busy,
   output logic               err,
   output logic [1:0]         state_dbg
);

   isr_state_e          state_q, state_d;
   logic [2:0]          exp_tag_q, exp_tag_d;
   logic [VIN-1:0]      vin_q, vin_d;
   logic [ROUT-1:0]     r_q, r_d;
   logic [VOUT-1:0]     v_q, v_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WIDX_W-1:0]   widx_q, widx_d;
   logic                err_q, err_d;
   logic                run_q, run_d;
   logic                din_ready_q, din_ready_d;
   logic                dout_valid_q, dout_valid_d;

   logic [2:0]          din_tag;
   logic [PAY_W-1:0]    din_pay;
   logic                unused_flag;
   logic                din_fire;
   logic                tag_ok;
   logic                last_load;
   logic                timeout_hit;
   logic                dout_fire;
   logic                last_word;
   logic [DATAOUT-1:0]  pack_word;

   // Handshake: a word moves on a rising clk edge when its valid and ready are both high.
   assign din_tag     = din[47:45];
   assign din_pay     = din[43:0];
   assign unused_flag = din[44];
   assign din_fire    = din_valid & din_ready_q & (state_q == ST_LOAD);
   assign tag_ok      = (din_tag == exp_tag_q);
   assign last_load   = din_fire & tag_ok & (exp_tag_q == TAG_V2);
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
   assign dout_fire   = dout_valid_q & dout_ready;
   assign last_word   = dout_fire & (widx_q == LAST_WIDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // calcend is tested before the timeout so a simultaneous finish still completes.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_LOAD: begin
            if (last_load) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (calcend)          state_d = ST_DRAIN;
            else if (timeout_hit) state_d = ST_LOAD;
         end
         ST_DRAIN: begin
            if (last_word) state_d = ST_LOAD;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_comb begin
      run_d        = 1'b0;
      din_ready_d  = 1'b0;
      dout_valid_d = 1'b0;
      unique case (state_d)
         ST_LOAD:  din_ready_d = 1'b1;
         ST_RUN:   run_d       = 1'b1;
         ST_DRAIN: begin
            run_d        = 1'b1;
            dout_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      exp_tag_d = exp_tag_q;
      vin_d     = vin_q;
      r_d       = r_q;
      v_d       = v_q;
      cnt_d     = cnt_q;
      widx_d    = widx_q;
      err_d     = err_q;
      unique case (state_q)
         ST_LOAD: begin
            cnt_d  = '0;
            widx_d = '0;
            if (din_fire) begin
               if (tag_ok) begin
                  unique case (exp_tag_q)
                     TAG_V0: begin
                        vin_d[127:84] = din_pay;
                        exp_tag_d     = TAG_V1;
                        err_d         = 1'b0;
                     end
                     TAG_V1: begin
                        vin_d[83:40] = din_pay;
                        exp_tag_d    = TAG_V2;
                     end
                     default: begin
                        vin_d[39:0] = din_pay[43:4];
                        exp_tag_d   = TAG_V0;
                     end
                  endcase
               end else if (din_tag == TAG_V0) begin
                  // An out-of-sequence first word restarts the radicand rather than erroring.
                  vin_d[127:84] = din_pay;
                  exp_tag_d     = TAG_V1;
                  err_d         = 1'b0;
               end else begin
                  err_d     = 1'b1;
                  exp_tag_d = TAG_V0;
               end
            end
         end
         ST_RUN: begin
            if (calcend) begin
               r_d    = rout;
               v_d    = vout;
               widx_d = '0;
            end else if (timeout_hit) begin
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (dout_fire) widx_d = widx_q + 3'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_tag_q    <= TAG_V0;
         vin_q        <= '0;
         r_q          <= '0;
         v_q          <= '0;
         cnt_q        <= '0;
         widx_q       <= '0;
         err_q        <= 1'b0;
         run_q        <= 1'b0;
         din_ready_q  <= 1'b0;
         dout_valid_q <= 1'b0;
      end else begin
         exp_tag_q    <= exp_tag_d;
         vin_q        <= vin_d;
         r_q          <= r_d;
         v_q          <= v_d;
         cnt_q        <= cnt_d;
         widx_q       <= widx_d;
         err_q        <= err_d;
         run_q        <= run_d;
         din_ready_q  <= din_ready_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   isr_pack u_pack (
      .idx  (widx_q),
      .v    (v_q),
      .r    (r_q),
      .word (pack_word)
   );

   // Output words come only from the captured registers, so core activity in DRAIN is ignored.
   assign dout       = dout_valid_q ? pack_word : '0;
   assign dout_valid = dout_valid_q;
   assign din_ready  = din_ready_q;
   assign vin        = vin_q;
   assign run        = run_q;
   assign err        = err_q;
   assign busy       = (state_q != ST_LOAD);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_isr_ctrl.sv
// Self-checking bench for isr_ctrl: table-driven load vectors, directed corner sequences,
// and randomized transactions scored against a chunk-level protocol model and a queue.
module tb_isr_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [47:0]  din;
   logic         din_valid;
   logic         din_ready;
   logic [127:0] vin;
   logic         run;
   logic         calcend;
   logic [128:0] rout;
   logic [127:0] vout;
   logic [47:0]  dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         busy;
   logic         err;
   logic [1:0]   state_dbg;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [47:0]  exp_q[$];

   // Model: the radicand as three 44-bit slots of a 132-bit container, plus tag/err bookkeeping.
   logic [131:0] m_vin;
   int           m_exp;
   bit           m_err;
   bit           m_run;

   typedef struct {
      logic [47:0] w;
      logic        exp_err;
      logic        exp_busy;
   } vec_t;
   vec_t tbl[11];

   always #5 clk = ~clk;

   isr_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .vin        (vin),
      .run        (run),
      .calcend    (calcend),
      .rout       (rout),
      .vout       (vout),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .err        (err),
      .state_dbg  (state_dbg)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [128:0] act, input logic [128:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   function automatic void isqrt(input logic [127:0] x, output logic [127:0] root,
                                 output logic [128:0] rem);
      logic [127:0] cand;
      root = '0;
      for (int b = 63; b >= 0; b--) begin
         cand = root | (128'd1 << b);
         if (cand * cand <= x) root = cand;
      end
      rem = {1'b0, x - root * root};
   endfunction

   function automatic void push_words(input logic [127:0] v, input logic [128:0] r);
      logic [131:0] vc;
      logic [131:0] rc;
      vc = {v, 4'b0000};
      rc = {r, 3'b000};
      for (int k = 0; k < 3; k++) exp_q.push_back({3'(k + 1), 1'b0, vc[131 - 44*k -: 44]});
      for (int k = 0; k < 3; k++) exp_q.push_back({3'(k + 4), 1'b1, rc[131 - 44*k -: 44]});
   endfunction

   task automatic model_reset();
      m_vin = '0;
      m_exp = 1;
      m_err = 1'b0;
      m_run = 1'b0;
      exp_q.delete();
   endtask

   task automatic send_word(input logic [47:0] w);
      logic [2:0] tag;
      int         k;
      din       = w;
      din_valid = 1'b1;
      for (int i = 0; i < 16 && !din_ready; i++) step();
      check("din_ready_before_send", din_ready, 1'b1);
      step();
      din_valid = 1'b0;
      din       = 48'($urandom);
      tag       = w[47:45];
      m_run     = 1'b0;
      if (tag == 3'(m_exp) || tag == 3'd1) begin
         k = (tag == 3'd1) ? 0 : m_exp - 1;
         m_vin[131 - 44*k -: 44] = w[43:0];
         if (k == 0) m_err = 1'b0;
         if (k == 2) begin
            m_run = 1'b1;
            m_exp = 1;
         end else begin
            m_exp = k + 2;
         end
      end else begin
         m_err = 1'b1;
         m_exp = 1;
      end
      check("err_model", err, m_err);
      check("vin_model", vin, m_vin[131:4]);
      check("run_after_word", run, m_run);
      check("din_ready_after_word", din_ready, !m_run);
   endtask

   task automatic load_vin(input logic [127:0] v);
      logic [131:0] c;
      c = {v, 4'($urandom)};
      for (int k = 0; k < 3; k++) send_word({3'(k + 1), 1'($urandom), c[131 - 44*k -: 44]});
   endtask

   task automatic core_respond(input int lat, input logic [127:0] v, input logic [128:0] r);
      for (int i = 0; i < lat; i++) step();
      calcend = 1'b1;
      vout    = v;
      rout    = r;
      step();
      check("first_word_valid", dout_valid, 1'b1);
      check("err_after_capture", err, m_err);
   endtask

   task automatic drain_words(input int n_words, input int stall_at, input int stall_len,
                              input bit rnd_bp);
      logic [47:0] held;
      bit          have_held;
      bit          rdy;
      int          got;
      int          stalls;
      got       = 0;
      stalls    = 0;
      have_held = 1'b0;
      held      = '0;
      for (int cyc = 0; cyc < 200 && got < n_words; cyc++) begin
         calcend = 1'($urandom);
         vout    = {$urandom, $urandom, $urandom, $urandom};
         rout    = {1'($urandom), $urandom, $urandom, $urandom, $urandom};
         rdy     = 1'b1;
         if (rnd_bp) rdy = ($urandom_range(0, 2) != 0);
         if (got == stall_at && stalls < stall_len) begin
            rdy = 1'b0;
            stalls++;
         end
         dout_ready = rdy;
         check("dout_valid_in_drain", dout_valid, 1'b1);
         if (!dout_valid) break;
         if (have_held) check("dout_stable", dout, held);
         if (rdy) begin
            if (exp_q.size() == 0) check("exp_q_nonempty", exp_q.size(), 1);
            else check("dout_word", dout, exp_q.pop_front());
            got++;
            have_held = 1'b0;
         end else begin
            held      = dout;
            have_held = 1'b1;
         end
         step();
      end
      check("words_drained", got, n_words);
      dout_ready = 1'b0;
      calcend    = 1'b0;
      if (n_words == 6) begin
         check("end_run", run, 1'b0);
         check("end_dout_valid", dout_valid, 1'b0);
         check("end_busy", busy, 1'b0);
         check("end_din_ready", din_ready, 1'b1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_din_ready"}, din_ready, 1'b0);
      check({tag, "_run"}, run, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_dout_valid"}, dout_valid, 1'b0);
      check({tag, "_dout"}, dout, 48'h0);
      check({tag, "_vin"}, vin, 128'h0);
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      #1;
      check("din_ready_before_edge", din_ready, 1'b0);
      step();
      check("din_ready_after_edge", din_ready, 1'b1);
   endtask

   initial begin
      #700000;
      $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] v;
      logic [127:0] root;
      logic [128:0] rem;
      int           tcnt;

      tbl[0]  = '{48'h2000_0000_0000, 1'b0, 1'b0};
      tbl[1]  = '{48'h6000_0000_0000, 1'b1, 1'b0};
      tbl[2]  = '{48'h4000_0000_0000, 1'b1, 1'b0};
      tbl[3]  = '{48'h2000_0000_0001, 1'b0, 1'b0};
      tbl[4]  = '{48'h4123_4567_89AB, 1'b0, 1'b0};
      tbl[5]  = '{48'h2AAA_AAAA_AAAA, 1'b0, 1'b0};
      tbl[6]  = '{48'h8000_0000_0000, 1'b1, 1'b0};
      tbl[7]  = '{48'hE000_0000_0000, 1'b1, 1'b0};
      tbl[8]  = '{48'h3000_0000_0005, 1'b0, 1'b0};
      tbl[9]  = '{48'h5000_0000_0006, 1'b0, 1'b0};
      tbl[10] = '{48'h7000_0000_0123, 1'b0, 1'b1};

      rst_n      = 1'b0;
      din        = '0;
      din_valid  = 1'b0;
      calcend    = 1'b0;
      rout       = '0;
      vout       = '0;
      dout_ready = 1'b0;
      model_reset();

      // Reset values, then din_ready rising on the first edge after release.
      step();
      step();
      check_all_zero("reset");
      release_reset();

      // Nominal transaction with fixed words.
      send_word(48'h2000_0000_0000);
      send_word(48'h4000_0000_0000);
      send_word(48'h6000_0000_0100);
      check("nominal_vin", vin, 128'h10);
      check("nominal_run", run, 1'b1);
      check("nominal_busy", busy, 1'b1);
      exp_q.push_back(48'h2000_0000_0000);
      exp_q.push_back(48'h4000_0000_0000);
      exp_q.push_back(48'h6000_0000_0040);
      exp_q.push_back(48'h9000_0000_0000);
      exp_q.push_back(48'hB000_0000_0000);
      exp_q.push_back(48'hD000_0000_0000);
      core_respond(2, 128'h4, 129'h0);
      drain_words(6, -1, 0, 1'b0);

      // Tag-sequence table: errors, fresh restarts, and a completing load.
      for (int i = 0; i < 11; i++) begin
         send_word(tbl[i].w);
         check("tbl_err", err, tbl[i].exp_err);
         check("tbl_busy", busy, tbl[i].exp_busy);
      end
      check("tbl_vin", vin, {44'h5, 44'h6, 40'h12});
      isqrt(m_vin[131:4], root, rem);
      push_words(root, rem);
      core_respond(5, root, rem);
      drain_words(6, 2, 3, 1'b0);

      // Timeout with calcend held low.
      load_vin({$urandom, $urandom, $urandom, $urandom});
      calcend = 1'b0;
      tcnt    = 0;
      for (int i = 1; i <= 1100; i++) begin
         step();
         if (!run) begin
            tcnt = i;
            break;
         end
      end
      check("timeout_cycles", tcnt, 1024);
      m_err = 1'b1;
      m_exp = 1;
      check("timeout_err", err, m_err);
      check("timeout_din_ready", din_ready, 1'b1);
      check("timeout_busy", busy, 1'b0);

      // calcend on the very last counted cycle beats the timeout.
      load_vin({$urandom, $urandom, $urandom, $urandom});
      check("err_cleared_by_load", err, 1'b0);
      isqrt(m_vin[131:4], root, rem);
      push_words(root, rem);
      core_respond(1023, root, rem);
      drain_words(6, -1, 0, 1'b0);

      // Randomized transactions, some preceded by a stray word.
      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(0, 1) == 1)
            send_word({3'($urandom_range(1, 7)), 45'({$urandom, $urandom})});
         v = {$urandom, $urandom, $urandom, $urandom};
         if (it == 0) v = '1;
         load_vin(v);
         isqrt(m_vin[131:4], root, rem);
         push_words(root, rem);
         core_respond($urandom_range(0, 30), root, rem);
         drain_words(6, $urandom_range(0, 5), $urandom_range(0, 3), 1'(it));
      end

      // Reset in the middle of DRAIN, then a normal transaction.
      load_vin({$urandom, $urandom, $urandom, $urandom});
      isqrt(m_vin[131:4], root, rem);
      push_words(root, rem);
      core_respond(3, root, rem);
      drain_words(3, -1, 0, 1'b0);
      dout_ready = 1'b1;
      rst_n      = 1'b0;
      #1;
      check_all_zero("mid_drain_reset");
      model_reset();
      step();
      step();
      dout_ready = 1'b0;
      release_reset();
      for (int i = 0; i < 4; i++) begin
         check("post_reset_no_dout", dout_valid, 1'b0);
         check("post_reset_no_run", run, 1'b0);
         step();
      end
      load_vin({$urandom, $urandom, $urandom, $urandom});
      isqrt(m_vin[131:4], root, rem);
      push_words(root, rem);
      core_respond(4, root, rem);
      drain_words(6, 1, 2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
